// File: rtl/dec_pkg.sv
// Shared types and helpers for the pipelined one-hot decoder.
// The range-check option is enabled with the DEC_RANGE_CHK_EN macro.
package dec_pkg;

  localparam int OUT_W_MAX = 64;

  function automatic int dec_idx_w(input int n);
    return $clog2(n);
  endfunction

  // Widest possible stored entry; a narrower build keeps only its low OUT_W word bits.
  typedef struct packed {
    logic [OUT_W_MAX-1:0] word;
    logic                 err;
  } dec_entry_t;

  // Occupancy of the 2-entry skid buffer: output register only, or output plus skid.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/dec_skid_buf.sv
// Generic 2-entry valid/ready skid register with a registered in_ready_o.
// Handshake: a beat moves on a rising edge where valid and ready are both high; out_data_o holds while stalled.
module dec_skid_buf
  import dec_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output skid_state_e       state_o
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              accept;
  logic              pop;

  assign accept = in_valid_i & in_ready_q;
  assign pop    = (state_q != SKID_EMPTY) & out_ready_i;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          out_d   = in_data_i;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && pop) begin
          out_d = in_data_i;
        end else if (accept) begin
          skid_d  = in_data_i;
          state_d = SKID_FULL;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          out_d   = skid_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    in_ready_d = (state_d != SKID_FULL);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= SKID_EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready_o = in_ready_q;
  assign out_data_o = out_q;
  assign state_o    = state_q;

endmodule

// File: rtl/decoder_using_pipe.sv
// Binary-to-one-hot decoder behind a valid/ready skid buffer; decode happens at accept time.
// Define DEC_RANGE_CHK_EN to add the range_err output that travels with each word.
module decoder_using_pipe
  import dec_pkg::*;
#(
  parameter  int OUT_W = 16,
  localparam int IN_W  = dec_idx_w(OUT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  binary_in,
  input  logic             enable,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef DEC_RANGE_CHK_EN
  output logic             range_err,
`endif
  output logic [OUT_W-1:0] decoder_out
);

`ifdef DEC_RANGE_CHK_EN
  localparam int ERR_W = 1;
`else
  localparam int ERR_W = 0;
`endif
  localparam int ENTRY_W = OUT_W + ERR_W;

  logic [OUT_W-1:0]   dec_word;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] out_entry;
  skid_state_e        skid_state;

  // Only indices below OUT_W have a line, so out-of-range codes give an all-zero word.
  always_comb begin
    dec_word = '0;
    for (int i = 0; i < OUT_W; i++) begin
      dec_word[i] = enable && (binary_in == IN_W'(i));
    end
  end

`ifdef DEC_RANGE_CHK_EN
  logic dec_err;
  assign dec_err     = enable && (32'(binary_in) >= OUT_W);
  assign in_entry    = {dec_word, dec_err};
  assign decoder_out = out_entry[ENTRY_W-1:1];
  assign range_err   = out_entry[0];
`else
  assign in_entry    = dec_word;
  assign decoder_out = out_entry;
`endif

  dec_skid_buf #(
    .DATA_W(ENTRY_W)
  ) u_skid (
    .clk_i      (clk),
    .rst_i      (reset),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_entry),
    .out_ready_i(out_ready),
    .out_data_o (out_entry),
    .state_o    (skid_state)
  );

  assign out_valid = (skid_state != SKID_EMPTY);

endmodule

// File: tb/tb_decoder_using_pipe.sv
// Directed plus randomised bench for decoder_using_pipe (OUT_W=16 and OUT_W=12 instances).
module tb_decoder_using_pipe;
  import dec_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, enable, out_valid, out_ready;
  logic [3:0]  binary_in;
  logic [15:0] decoder_out;
  logic        in_valid12, in_ready12, en12, out_valid12, out_ready12;
  logic [3:0]  bin12;
  logic [11:0] dout12;
`ifdef DEC_RANGE_CHK_EN
  logic        range_err, range_err12;
`endif

  decoder_using_pipe #(.OUT_W(16)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .binary_in  (binary_in),
    .enable     (enable),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef DEC_RANGE_CHK_EN
    .range_err  (range_err),
`endif
    .decoder_out(decoder_out)
  );

  decoder_using_pipe #(.OUT_W(12)) u_dut12 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid12),
    .in_ready   (in_ready12),
    .binary_in  (bin12),
    .enable     (en12),
    .out_valid  (out_valid12),
    .out_ready  (out_ready12),
`ifdef DEC_RANGE_CHK_EN
    .range_err  (range_err12),
`endif
    .decoder_out(dout12)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drivers act just after the rising edge; checks happen on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a pop is committed at the next rising edge when valid & ready are seen here.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        check_eq("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check_eq("sb_word", decoder_out, exp_q.pop_front());
`ifdef DEC_RANGE_CHK_EN
        check_eq("sb_range_err", range_err, 1'b0);
`endif
      end
      if (in_valid && in_ready) exp_q.push_back(enable ? (16'h0001 << binary_in) : 16'h0000);
    end
  end

  always @(posedge reset) exp_q.delete();

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] onehot_tbl [16];
  dec_entry_t  e12;

  initial begin
    onehot_tbl = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080,
                   16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h8000};
    reset = 1'b1; in_valid = 1'b0; binary_in = '0; enable = 1'b0; out_ready = 1'b0;
    in_valid12 = 1'b0; bin12 = '0; en12 = 1'b0; out_ready12 = 1'b1;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_dout", decoder_out, 16'h0000);
    tick(); reset = 1'b0;
    tick();
    @(negedge clk);
    check_eq("rel_in_ready", in_ready, 1'b1);
    check_eq("rel_out_valid", out_valid, 1'b0);

    // Single decode of 5, one cycle latency
    tick(); in_valid = 1'b1; binary_in = 4'd5; enable = 1'b1; out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check_eq("dec5_valid", out_valid, 1'b1);
    check_eq("dec5_word", decoder_out, 16'h0020);

    // Stream 0..15 back to back at full rate
    for (int i = 0; i <= 16; i++) begin
      tick();
      if (i < 16) begin in_valid = 1'b1; binary_in = 4'(i); end
      else in_valid = 1'b0;
      if (i > 0) begin
        @(negedge clk);
        check_eq($sformatf("stream%0d_word", i - 1), decoder_out, onehot_tbl[i-1]);
        check_eq("stream_valid", out_valid, 1'b1);
        check_eq("stream_in_ready", in_ready, 1'b1);
      end
    end

    // enable=0 gives a zero word but still handshakes
    tick(); in_valid = 1'b1; binary_in = 4'd9; enable = 1'b0;
    tick(); in_valid = 1'b0; enable = 1'b1;
    @(negedge clk);
    check_eq("en0_valid", out_valid, 1'b1);
    check_eq("en0_word", decoder_out, 16'h0000);

    // Back-pressure fills the skid, then drains in order
    tick(); out_ready = 1'b0; in_valid = 1'b1; binary_in = 4'd3;
    tick(); binary_in = 4'd7;
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_in_ready", in_ready, 1'b0);
    check_eq("bp_word0", decoder_out, 16'h0008);
    tick();
    @(negedge clk);
    check_eq("bp_stall_word", decoder_out, 16'h0008);
    check_eq("bp_stall_valid", out_valid, 1'b1);
    tick(); out_ready = 1'b1;
    tick();
    @(negedge clk);
    check_eq("bp_word1", decoder_out, 16'h0080);
    check_eq("bp_ready_back", in_ready, 1'b1);
    tick();
    @(negedge clk);
    check_eq("bp_drained", out_valid, 1'b0);

    // Reset with both entries full
    tick(); out_ready = 1'b0; in_valid = 1'b1; binary_in = 4'd2;
    tick(); binary_in = 4'd4;
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check_eq("full_in_ready", in_ready, 1'b0);
    check_eq("full_word", decoder_out, 16'h0004);
    tick(); reset = 1'b1;
    #1;
    check_eq("mrst_out_valid", out_valid, 1'b0);
    check_eq("mrst_dout", decoder_out, 16'h0000);
    check_eq("mrst_in_ready", in_ready, 1'b0);
    tick(); reset = 1'b0;
    @(negedge clk);
    check_eq("mrst_in_ready_low", in_ready, 1'b0);
    tick();
    @(negedge clk);
    check_eq("mrst_in_ready_up", in_ready, 1'b1);
    check_eq("mrst_no_word", out_valid, 1'b0);

    // OUT_W=12: out-of-range index 13, then top line 11
    tick(); in_valid12 = 1'b1; bin12 = 4'd13; en12 = 1'b1;
    tick(); bin12 = 4'd11;
    @(negedge clk);
    e12 = '{word: 64'h0, err: 1'b1};
    check_eq("w12_oor_valid", out_valid12, 1'b1);
    check_eq("w12_oor_word", dout12, e12.word[11:0]);
`ifdef DEC_RANGE_CHK_EN
    check_eq("w12_oor_err", range_err12, e12.err);
`endif
    tick(); bin12 = 4'd13; en12 = 1'b0;
    @(negedge clk);
    e12 = '{word: 64'h800, err: 1'b0};
    check_eq("w12_top_word", dout12, e12.word[11:0]);
`ifdef DEC_RANGE_CHK_EN
    check_eq("w12_top_err", range_err12, e12.err);
`endif
    tick(); in_valid12 = 1'b0;
    @(negedge clk);
    check_eq("w12_dis_word", dout12, 12'h000);
`ifdef DEC_RANGE_CHK_EN
    check_eq("w12_dis_err", range_err12, 1'b0);
`endif

    // Random valid/ready traffic against the scoreboard
    for (int c = 0; c < 3000; c++) begin
      tick();
      in_valid  = 1'($urandom_range(0, 1));
      binary_in = 4'($urandom_range(0, 15));
      enable    = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
    end
    tick(); in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    @(negedge clk);
    check_eq("drain_queue_empty", exp_q.size(), 0);
    check_eq("drain_out_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
